spu_simd_alu_pipe: RTL

//  Next-generation SIMD integer ALU for the SPU execute stage. Takes two DATA_WIDTH operand vectors and an opcode, and computes halfword/word lane operations.

---
 rtl/spu_simd_alu_pipe.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/spu_simd_alu_pipe.sv
// spu_simd_alu_pipe: SIMD integer ALU for the SPU execute stage.
//   Halfword/word lane ops with per-op latency, valid/ready on both sides,
//   single issue, in-order results, per-word zero flags and illegal-op flag.
//   Optional feature macro: SPU_ALU_SAT_EN (AH/AHI/SFH saturate as signed 16-bit).
// Ports:
//   clk_fake, rst (async, active-high)
//   in_valid/in_ready, op_code[5:0], in_a, in_b          : issue side
//   out_valid/out_ready, data_out, zero_out[NW-1:0], illegal_op : result side
module spu_simd_alu_pipe #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned MUL_LAT    = 2,
  parameter int unsigned SH_LAT     = 2
) (
  input  logic                      clk_fake,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [5:0]                op_code,
  input  logic [DATA_WIDTH-1:0]     in_a,
  input  logic [DATA_WIDTH-1:0]     in_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic [DATA_WIDTH/32-1:0]  zero_out,
  output logic                      illegal_op
);

  localparam int unsigned NW      = DATA_WIDTH / 32;
  localparam int unsigned NH      = 2 * NW;
  localparam int unsigned MAX_LAT = (MUL_LAT > SH_LAT) ? MUL_LAT : SH_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [5:0] OP_ILH  = 6'd0;
  localparam logic [5:0] OP_IL   = 6'd2;
  localparam logic [5:0] OP_AH   = 6'd4;
  localparam logic [5:0] OP_AHI  = 6'd6;
  localparam logic [5:0] OP_SFH  = 6'd12;
  localparam logic [5:0] OP_SHLH = 6'd14;
  localparam logic [5:0] OP_ROTH = 6'd16;
  localparam logic [5:0] OP_MPY  = 6'd20;
  localparam logic [5:0] OP_AND  = 6'd28;
  localparam logic [5:0] OP_OR   = 6'd30;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state, state_nx;
  logic [CNT_W-1:0]        cnt, cnt_nx;
  logic [5:0]              op_q, op_nx;
  logic [DATA_WIDTH-1:0]   a_q, a_nx, b_q, b_nx;
  logic [DATA_WIDTH-1:0]   data_nx;
  logic [NW-1:0]           zero_nx;
  logic                    ill_nx, valid_nx, accept;

  // Remaining cycles after the accept edge; zero means the result lands on the accept edge.
  function automatic logic [CNT_W-1:0] op_cnt(input logic [5:0] op);
    case (op)
      OP_MPY:           op_cnt = CNT_W'(MUL_LAT - 1);
      OP_SHLH, OP_ROTH: op_cnt = CNT_W'(SH_LAT - 1);
      default:          op_cnt = '0;
    endcase
  endfunction

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_ILH, OP_IL, OP_AH, OP_AHI, OP_SFH, OP_SHLH,
      OP_ROTH, OP_MPY, OP_AND, OP_OR: op_legal = 1'b1;
      default:                        op_legal = 1'b0;
    endcase
  endfunction

  // Lane add/sub: wrap by default, signed clamp when saturation is built in.
  function automatic logic [15:0] add16(input logic [15:0] x, input logic [15:0] y);
`ifdef SPU_ALU_SAT_EN
    logic [16:0] s;
    s = {x[15], x} + {y[15], y};
    if (s[16] != s[15]) add16 = s[16] ? 16'h8000 : 16'h7FFF;
    else                add16 = s[15:0];
`else
    add16 = x + y;
`endif
  endfunction

  function automatic logic [15:0] sub16(input logic [15:0] x, input logic [15:0] y);
`ifdef SPU_ALU_SAT_EN
    logic [16:0] s;
    s = {x[15], x} - {y[15], y};
    if (s[16] != s[15]) sub16 = s[16] ? 16'h8000 : 16'h7FFF;
    else                sub16 = s[15:0];
`else
    sub16 = x - y;
`endif
  endfunction

  function automatic logic [DATA_WIDTH-1:0] alu(input logic [5:0] op,
                                                input logic [DATA_WIDTH-1:0] a,
                                                input logic [DATA_WIDTH-1:0] b);
    logic [31:0] rot;
    alu = '0;
    rot = '0;
    case (op)
      OP_ILH:  for (int h = 0; h < NH; h += 2) alu[h*16 +: 16] = b[15:0];
      OP_IL:   for (int w = 0; w < NW; w++) alu[w*32 +: 32] = b[31:0];
      OP_AH:   for (int h = 0; h < NH; h++) alu[h*16 +: 16] = add16(b[h*16 +: 16], a[h*16 +: 16]);
      OP_AHI:  for (int h = 0; h < NH; h++) alu[h*16 +: 16] = add16(b[15:0], a[h*16 +: 16]);
      OP_SFH:  for (int h = 0; h < NH; h++) alu[h*16 +: 16] = sub16(b[h*16 +: 16], a[h*16 +: 16]);
      OP_SHLH: for (int h = 0; h < NH; h++)
                 alu[h*16 +: 16] = b[4] ? 16'h0000 : (a[h*16 +: 16] << b[3:0]);
      OP_ROTH: for (int h = 0; h < NH; h++) begin
                 // upper half of the doubled lane shifted left is the rotate
                 rot = {a[h*16 +: 16], a[h*16 +: 16]} << b[3:0];
                 alu[h*16 +: 16] = rot[31:16];
               end
      OP_MPY:  for (int w = 0; w < NW; w++)
                 alu[w*32 +: 32] = 32'(a[w*32 +: 16]) * 32'(b[w*32 +: 16]);
      OP_AND:  alu = a & b;
      OP_OR:   alu = a | b;
      default: alu = '0;
    endcase
  endfunction

  assign in_ready = ~rst & ((state == IDLE) | ((state == DONE) & out_ready));
  assign accept   = in_valid & in_ready;

  // Next-state, operand capture and result registration.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    op_nx    = op_q;
    a_nx     = a_q;
    b_nx     = b_q;
    data_nx  = data_out;
    ill_nx   = illegal_op;
    valid_nx = out_valid;
    zero_nx  = '0;
    case (state)
      IDLE, DONE: begin
        if ((state == DONE) && out_ready) begin
          valid_nx = 1'b0;
          state_nx = IDLE;
        end
        if (accept) begin
          op_nx = op_code;
          a_nx  = in_a;
          b_nx  = in_b;
          if (op_cnt(op_code) == '0) begin
            data_nx  = alu(op_code, in_a, in_b);
            ill_nx   = ~op_legal(op_code);
            valid_nx = 1'b1;
            state_nx = DONE;
          end else begin
            cnt_nx   = op_cnt(op_code);
            state_nx = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          data_nx  = alu(op_q, a_q, b_q);
          ill_nx   = ~op_legal(op_q);
          valid_nx = 1'b1;
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
    for (int w = 0; w < NW; w++) zero_nx[w] = (data_nx[w*32 +: 32] == 32'd0);
  end

  // State and result registers; reset discards any op in flight.
  always_ff @(posedge clk_fake or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      data_out   <= '0;
      zero_out   <= '0;
      illegal_op <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      op_q       <= op_nx;
      a_q        <= a_nx;
      b_q        <= b_nx;
      data_out   <= data_nx;
      zero_out   <= zero_nx;
      illegal_op <= ill_nx;
      out_valid  <= valid_nx;
    end
  end

endmodule
